data_mem_responder: RTL and testbench

- Memory-side responder for the nRisc data port. It answers the core's LerMem/EscMem strobes with a wait-stated, handshaked 256x8 data store.
- It replaces the zero-latency memory with a bounded-latency slave that signals completion on Pronto. The core's stall logic uses Pronto to hold the PC.
- Sits between the core (address from Data1, write data from Data2, LeDado back to the writeback mux) and the storage array.

---
 rtl/data_mem_responder.sv | 76 +++++++
 tb/tb_data_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated, handshaked data memory slave for the nRisc data port.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              LerMem,
  input  logic              EscMem,
  input  logic [ADDR_W-1:0] Endereco,
  input  logic [DATA_W-1:0] DadoEscrita,
  output logic [DATA_W-1:0] LeDado,
  output logic              Pronto,
  output logic              Ocupado,
  output logic              Erro
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 0..15");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  state_t state;
  logic [3:0] cnt;
  logic op_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic start, direct, acc, acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  // With no wait states the access happens on the sample edge itself, straight from the inputs.
  always_comb begin
    start    = state == S_IDLE && (LerMem ^ EscMem);
    direct   = start && ZERO_WAIT;
    acc      = reset && (direct || (state == S_WAIT && cnt == 4'd1));
    acc_wr   = direct ? EscMem : op_wr;
    acc_addr = direct ? Endereco : addr;
    acc_data = direct ? DadoEscrita : wdata;
  end
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_wr  <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      LeDado <= '0;
      Erro   <= 1'b0;
    end else begin
      Erro <= state == S_IDLE && LerMem && EscMem;
      if (acc && !acc_wr) LeDado <= mem[acc_addr];
      case (state)
        S_IDLE: if (start) begin
          op_wr <= EscMem;
          addr  <= Endereco;
          wdata <= DadoEscrita;
          cnt   <= WC;
          state <= ZERO_WAIT ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge Clock) begin
    if (acc && acc_wr) mem[acc_addr] <= acc_data;
  end
  assign Pronto  = state == S_DONE;
  assign Ocupado = state != S_IDLE;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data memory responder with 2 and 0 wait states.
module tb_data_mem_responder;
  logic Clock, reset;
  logic ler2, esc2, ler0, esc0;
  logic [7:0] end2, din2, end0, din0;
  logic [7:0] le2, le0;
  logic pr2, oc2, er2, pr0, oc0, er0;
  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut2 (
    .Clock(Clock), .reset(reset), .LerMem(ler2), .EscMem(esc2), .Endereco(end2),
    .DadoEscrita(din2), .LeDado(le2), .Pronto(pr2), .Ocupado(oc2), .Erro(er2));
  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .Clock(Clock), .reset(reset), .LerMem(ler0), .EscMem(esc0), .Endereco(end0),
    .DadoEscrita(din0), .LeDado(le0), .Pronto(pr0), .Ocupado(oc0), .Erro(er0));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the 2-wait-state instance: Ocupado for 3 cycles, Pronto in the third.
  task automatic acc2(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] le);
    @(negedge Clock);
    chk("w2_idle_busy", oc2, 8'd0);
    ler2 = !wr; esc2 = wr; end2 = a; din2 = d;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      chk("w2_busy", oc2, 8'd1);
      chk("w2_pronto", pr2, (i == 3) ? 8'd1 : 8'd0);
    end
    chk("w2_ledado", le2, le);
    ler2 = 1'b0; esc2 = 1'b0;
    @(negedge Clock);
    chk("w2_busy_end", oc2, 8'd0);
    chk("w2_pronto_end", pr2, 8'd0);
  endtask

  task automatic acc0(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] le);
    @(negedge Clock);
    ler0 = !wr; esc0 = wr; end0 = a; din0 = d;
    @(negedge Clock);
    chk("w0_pronto", pr0, 8'd1);
    chk("w0_busy", oc0, 8'd1);
    chk("w0_ledado", le0, le);
    ler0 = 1'b0; esc0 = 1'b0;
    @(negedge Clock);
    chk("w0_pronto_end", pr0, 8'd0);
    chk("w0_busy_end", oc0, 8'd0);
  endtask

  initial begin
    reset = 1'b0;
    ler2 = 0; esc2 = 0; end2 = 0; din2 = 0;
    ler0 = 0; esc0 = 0; end0 = 0; din0 = 0;
    #2;
    chk("rst_ledado", le2, 8'h00);
    chk("rst_pronto", pr2, 8'd0);
    chk("rst_busy", oc2, 8'd0);
    chk("rst_erro", er2, 8'd0);
    repeat (2) @(negedge Clock);
    reset = 1'b1;

    acc2(1'b1, 8'h10, 8'hA5, 8'h00);
    acc2(1'b0, 8'h10, 8'h00, 8'hA5);

    acc0(1'b1, 8'h00, 8'h3C, 8'h00);
    acc0(1'b1, 8'h01, 8'hC3, 8'h00);
    acc0(1'b0, 8'h00, 8'h00, 8'h3C);
    // back-to-back reads held on the strobe: one completion every 2 cycles
    ler0 = 1'b1; end0 = 8'h00;
    @(negedge Clock);
    chk("b2b_pronto1", pr0, 8'd1);
    chk("b2b_data1", le0, 8'h3C);
    end0 = 8'h01;
    @(negedge Clock);
    chk("b2b_gap", pr0, 8'd0);
    @(negedge Clock);
    chk("b2b_pronto2", pr0, 8'd1);
    chk("b2b_data2", le0, 8'hC3);
    ler0 = 1'b0;
    @(negedge Clock);
    chk("b2b_idle", oc0, 8'd0);

    acc2(1'b1, 8'h40, 8'h5A, 8'hA5);
    @(negedge Clock);
    ler2 = 1'b1; esc2 = 1'b1; end2 = 8'h40; din2 = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk("err_erro", er2, 8'd1);
      chk("err_pronto", pr2, 8'd0);
      chk("err_busy", oc2, 8'd0);
    end
    ler2 = 1'b0; esc2 = 1'b0;
    @(negedge Clock);
    chk("err_clear", er2, 8'd0);
    acc2(1'b0, 8'h40, 8'h00, 8'h5A);

    acc2(1'b1, 8'h21, 8'h22, 8'h5A);
    @(negedge Clock);
    esc2 = 1'b1; end2 = 8'h20; din2 = 8'h11;
    @(negedge Clock);
    end2 = 8'h21; din2 = 8'hFF;
    @(negedge Clock);
    @(negedge Clock);
    chk("latch_pronto", pr2, 8'd1);
    esc2 = 1'b0;
    @(negedge Clock);
    acc2(1'b0, 8'h20, 8'h00, 8'h11);
    acc2(1'b0, 8'h21, 8'h00, 8'h22);

    acc2(1'b1, 8'h30, 8'h66, 8'h22);
    acc2(1'b1, 8'h31, 8'h42, 8'h22);
    @(negedge Clock);
    esc2 = 1'b1; end2 = 8'h30; din2 = 8'h77;
    @(negedge Clock);
    chk("abort_busy", oc2, 8'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_async_busy", oc2, 8'd0);
    chk("abort_async_ledado", le2, 8'h00);
    esc2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("abort_no_pronto", pr2, 8'd0);
    end
    reset = 1'b1;
    acc2(1'b0, 8'h30, 8'h00, 8'h66);
    acc2(1'b0, 8'h31, 8'h00, 8'h42);

    acc2(1'b1, 8'hFF, 8'h99, 8'h42);
    acc2(1'b0, 8'hFF, 8'h00, 8'h99);
    acc2(1'b1, 8'h02, 8'h01, 8'h99);
    @(negedge Clock);
    chk("ledado_hold", le2, 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
